// File: rtl/fp16_accumulator.sv
// Half-precision accumulator: sums i_len products arriving on a valid/ready port
// through a four-cycle ALIGN/ADD/NORM loop, truncating and flushing denormals to zero.
module fp16_accumulator #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic [15:0]      i_prod,
  input  logic             i_prod_vld,
  input  logic             i_exception,
  input  logic             i_overflow,
  input  logic             i_underflow,
  output logic             o_ready,
  output logic             o_busy,
  output logic [15:0]      o_sum,
  output logic             o_sum_vld,
  output logic [3:0]       o_flags,
  output logic [2:0]       dbg_state
);

  // Handshake: an element transfers on a rising edge where i_prod_vld & o_ready;
  // o_ready is high only while waiting for the next element, so the producer may
  // hold i_prod_vld and the surplus cycles are counted as drops.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_ALIGN = 3'd2,
    S_ADD   = 3'd3,
    S_NORM  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [LEN_W-1:0] count;
  logic [15:0]      acc, op;

  logic        al_sb, al_ss, al_spec, al_spec_s;
  logic [4:0]  al_exp;
  logic [10:0] al_mb, al_ms;

  logic        ad_s, ad_spec, ad_spec_s;
  logic [4:0]  ad_exp;
  logic [11:0] ad_man;

  // ALIGN combinational signals
  logic [4:0]  a_exp, o_exp, e_big, e_sml, e_diff;
  logic [10:0] a_man, o_man, m_big, m_sml, m_shf;
  logic        s_big, s_sml, c_spec, c_spec_s;

  // ADD combinational signals
  logic [11:0] c_man;
  logic        c_s;

  // NORM combinational signals
  logic [3:0]        lz;
  logic [10:0]       n_man;
  logic signed [6:0] n_exp;
  logic [15:0]       n_res;
  logic [2:0]        n_flags;
  logic [3:0]        flag_set;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = (i_len == '0) ? S_DONE : S_WAIT;
      S_WAIT:  if (i_prod_vld) state_nxt = S_ALIGN;
      S_ALIGN: state_nxt = S_ADD;
      S_ADD:   state_nxt = S_NORM;
      S_NORM:  state_nxt = (count == LEN_W'(1)) ? S_DONE : S_WAIT;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_ready   = (state == S_WAIT);
    o_busy    = (state != S_IDLE);
    o_sum_vld = (state == S_DONE);
    dbg_state = state;
  end

  // Exponent compare and mantissa alignment; exponent 0 is flushed to zero.
  always_comb begin
    a_exp = acc[14:10];
    o_exp = op[14:10];
    a_man = (a_exp == 5'd0) ? 11'd0 : {1'b1, acc[9:0]};
    o_man = (o_exp == 5'd0) ? 11'd0 : {1'b1, op[9:0]};
    if (o_exp > a_exp) begin
      e_big = o_exp; m_big = o_man; s_big = op[15];
      e_sml = a_exp; m_sml = a_man; s_sml = acc[15];
    end else begin
      e_big = a_exp; m_big = a_man; s_big = acc[15];
      e_sml = o_exp; m_sml = o_man; s_sml = op[15];
    end
    e_diff   = e_big - e_sml;
    m_shf    = (e_diff >= 5'd12) ? 11'd0 : (m_sml >> e_diff);
    c_spec   = (a_exp == 5'h1F) || (o_exp == 5'h1F);
    c_spec_s = (a_exp == 5'h1F) ? acc[15] : op[15];
  end

  // Magnitude add or subtract; an exact cancel yields +0.
  always_comb begin
    c_s   = al_sb;
    c_man = 12'd0;
    if (al_sb == al_ss) begin
      c_man = {1'b0, al_mb} + {1'b0, al_ms};
    end else if (al_mb >= al_ms) begin
      c_man = {1'b0, al_mb} - {1'b0, al_ms};
    end else begin
      c_man = {1'b0, al_ms} - {1'b0, al_mb};
      c_s   = al_ss;
    end
    if (c_man == 12'd0) c_s = 1'b0;
  end

  // Normalise, then saturate to infinity or flush to signed zero.
  always_comb begin
    lz = 4'd0;
    for (int i = 0; i < 11; i++) begin
      if (ad_man[i]) lz = 4'(10 - i);
    end
    if (ad_man[11]) begin
      n_man = ad_man[11:1];
      n_exp = $signed({2'b00, ad_exp}) + 7'sd1;
    end else begin
      n_man = ad_man[10:0] << lz;
      n_exp = $signed({2'b00, ad_exp}) - $signed({3'b000, lz});
    end
    n_flags = 3'b000;
    if (ad_spec) begin
      n_res   = {ad_spec_s, 5'h1F, 10'h000};
      n_flags = 3'b100;
    end else if (ad_man == 12'd0) begin
      n_res = 16'h0000;
    end else if (n_exp >= 7'sd31) begin
      n_res   = {ad_s, 5'h1F, 10'h000};
      n_flags = 3'b010;
    end else if (n_exp < 7'sd1) begin
      n_res   = {ad_s, 15'h0000};
      n_flags = 3'b001;
    end else begin
      n_res = {ad_s, n_exp[4:0], n_man[9:0]};
    end
  end

  always_comb begin
    flag_set = 4'b0000;
    if (state == S_WAIT && i_prod_vld)
      flag_set[2:0] = {i_exception, i_overflow, i_underflow};
    if (state != S_IDLE && state != S_WAIT && i_prod_vld)
      flag_set[3] = 1'b1;
    if (state == S_NORM)
      flag_set[2:0] = flag_set[2:0] | n_flags;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      acc       <= 16'h0000;
      op        <= 16'h0000;
      o_sum     <= 16'h0000;
      o_flags   <= 4'b0000;
      al_sb     <= 1'b0;
      al_ss     <= 1'b0;
      al_spec   <= 1'b0;
      al_spec_s <= 1'b0;
      al_exp    <= 5'd0;
      al_mb     <= 11'd0;
      al_ms     <= 11'd0;
      ad_s      <= 1'b0;
      ad_spec   <= 1'b0;
      ad_spec_s <= 1'b0;
      ad_exp    <= 5'd0;
      ad_man    <= 12'd0;
    end else begin
      if (state == S_IDLE && i_start) o_flags <= 4'b0000;
      else                            o_flags <= o_flags | flag_set;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            count <= i_len;
            acc   <= 16'h0000;
            if (i_len == '0) o_sum <= 16'h0000;
          end
        end
        S_WAIT: begin
          if (i_prod_vld) op <= i_prod;
        end
        S_ALIGN: begin
          al_sb     <= s_big;
          al_ss     <= s_sml;
          al_exp    <= e_big;
          al_mb     <= m_big;
          al_ms     <= m_shf;
          al_spec   <= c_spec;
          al_spec_s <= c_spec_s;
        end
        S_ADD: begin
          ad_s      <= c_s;
          ad_exp    <= al_exp;
          ad_man    <= c_man;
          ad_spec   <= al_spec;
          ad_spec_s <= al_spec_s;
        end
        S_NORM: begin
          acc   <= n_res;
          o_sum <= n_res;
          count <= count - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_accumulator.sv
// Directed bench for fp16_accumulator: one task per scenario with hand-computed
// half-precision sums and flag vectors {drop, exc, ovf, unf}.
module tb_fp16_accumulator;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start;
  logic [LEN_W-1:0] i_len;
  logic [15:0]      i_prod;
  logic             i_prod_vld;
  logic             i_exception, i_overflow, i_underflow;
  logic             o_ready, o_busy, o_sum_vld;
  logic [15:0]      o_sum;
  logic [3:0]       o_flags;
  logic [2:0]       dbg_state;

  int errors = 0;
  int checks = 0;

  fp16_accumulator #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len),
    .i_prod(i_prod), .i_prod_vld(i_prod_vld),
    .i_exception(i_exception), .i_overflow(i_overflow), .i_underflow(i_underflow),
    .o_ready(o_ready), .o_busy(o_busy), .o_sum(o_sum), .o_sum_vld(o_sum_vld),
    .o_flags(o_flags), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Drives one run, presenting the next product whenever o_ready is seen.
  task automatic do_run(input int len, input logic [15:0] p0, input logic [15:0] p1,
                        input logic [15:0] p2, input logic [2:0] fl,
                        output logic [15:0] sum, output logic [3:0] flags,
                        output int vld_cnt, output bit timeout);
    logic [15:0] prods[3];
    int k;
    int after;
    bit seen;
    prods[0] = p0; prods[1] = p1; prods[2] = p2;
    k = 0; after = 0; seen = 0; vld_cnt = 0; timeout = 1;
    sum = 16'h0000; flags = 4'h0;
    @(negedge clk);
    i_start = 1'b1; i_len = LEN_W'(len);
    @(negedge clk);
    i_start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (o_sum_vld) begin
        vld_cnt++; sum = o_sum; flags = o_flags; seen = 1;
      end
      if (o_ready && k < len) begin
        i_prod_vld = 1'b1; i_prod = prods[k];
        {i_exception, i_overflow, i_underflow} = fl;
        k++;
      end else begin
        i_prod_vld = 1'b0;
        {i_exception, i_overflow, i_underflow} = 3'b000;
      end
      if (seen) begin
        after++;
        if (after > 4) begin
          timeout = 0;
          break;
        end
      end
      @(negedge clk);
    end
    i_prod_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (o_sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got=%h exp=0000", o_sum); end
    checks++; if (o_flags !== 4'h0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", o_flags); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", o_ready); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (o_sum_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", o_sum_vld); end
  endtask

  // Shared body for the plain value scenarios; each caller supplies its expectations.
  task automatic run_case(input string name, input int len, input logic [15:0] p0,
                          input logic [15:0] p1, input logic [15:0] p2, input logic [2:0] fl,
                          input logic [15:0] exp_sum, input logic [3:0] exp_flags);
    logic [15:0] sum;
    logic [3:0] flags;
    int vld_cnt;
    bit timeout;
    do_run(len, p0, p1, p2, fl, sum, flags, vld_cnt, timeout);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL %s_timeout got=no_sum_vld exp=sum_vld", name); end
    checks++; if (vld_cnt !== 1) begin errors++; $display("FAIL %s_vld_pulses got=%0d exp=1", name, vld_cnt); end
    checks++; if (sum !== exp_sum) begin errors++; $display("FAIL %s_sum got=%h exp=%h", name, sum, exp_sum); end
    checks++; if (flags !== exp_flags) begin errors++; $display("FAIL %s_flags got=%b exp=%b", name, flags, exp_flags); end
    checks++; if (o_sum !== exp_sum || o_busy !== 1'b0) begin
      errors++; $display("FAIL %s_hold got=%h/%b exp=%h/0", name, o_sum, o_busy, exp_sum);
    end
  endtask

  task automatic test_basic();     run_case("basic", 2, 16'h3C00, 16'h4000, 16'h0000, 3'b000, 16'h4200, 4'b0000); endtask
  task automatic test_cancel();    run_case("cancel", 2, 16'h3C00, 16'hBC00, 16'h0000, 3'b000, 16'h0000, 4'b0000); endtask
  task automatic test_overflow();  run_case("overflow", 2, 16'h7BFF, 16'h7BFF, 16'h0000, 3'b000, 16'h7C00, 4'b0010); endtask
  task automatic test_underflow(); run_case("underflow", 2, 16'h0400, 16'h8401, 16'h0000, 3'b000, 16'h8000, 4'b0001); endtask
  task automatic test_exception(); run_case("exception", 2, 16'h3C00, 16'hFC00, 16'h0000, 3'b000, 16'hFC00, 4'b0100); endtask
  task automatic test_truncate();  run_case("truncate", 3, 16'h3C00, 16'h1400, 16'h1000, 3'b000, 16'h3C01, 4'b0000); endtask
  task automatic test_in_flags();  run_case("in_flags", 1, 16'h3C00, 16'h0000, 16'h0000, 3'b011, 16'h3C00, 4'b0011); endtask

  task automatic test_drop();
    int ready_at[$];
    int cyc;
    bit seen;
    logic [15:0] sum;
    logic [3:0] flags;
    seen = 0; sum = 16'h0000; flags = 4'h0;
    @(negedge clk);
    i_start = 1'b1; i_len = LEN_W'(3);
    @(negedge clk);
    i_start = 1'b0;
    i_prod_vld = 1'b1; i_prod = 16'h3C00;
    for (cyc = 0; cyc < 100 && !seen; cyc++) begin
      if (o_ready) ready_at.push_back(cyc);
      if (o_sum_vld) begin seen = 1; sum = o_sum; flags = o_flags; end
      @(negedge clk);
    end
    i_prod_vld = 1'b0;
    @(negedge clk);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL drop_timeout got=no_sum_vld exp=sum_vld"); end
    checks++; if (ready_at.size() !== 3) begin errors++; $display("FAIL drop_ready_count got=%0d exp=3", ready_at.size()); end
    if (ready_at.size() >= 3) begin
      checks++; if (ready_at[1] - ready_at[0] !== 4) begin errors++; $display("FAIL drop_ready_gap1 got=%0d exp=4", ready_at[1] - ready_at[0]); end
      checks++; if (ready_at[2] - ready_at[1] !== 4) begin errors++; $display("FAIL drop_ready_gap2 got=%0d exp=4", ready_at[2] - ready_at[1]); end
    end
    checks++; if (sum !== 16'h4200) begin errors++; $display("FAIL drop_sum got=%h exp=4200", sum); end
    checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL drop_flags got=%b exp=1000", flags); end
  endtask

  task automatic test_reset_mid_run();
    int vld_seen;
    @(negedge clk);
    i_start = 1'b1; i_len = LEN_W'(3);
    @(negedge clk);
    i_start = 1'b0;
    i_prod_vld = 1'b1; i_prod = 16'h3C00;
    @(negedge clk);
    i_prod_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (o_sum !== 16'h4200) begin errors++; $display("FAIL latency_early got=%h exp=4200", o_sum); end
    @(negedge clk);
    checks++; if (o_sum !== 16'h3C00 || o_ready !== 1'b1) begin
      errors++; $display("FAIL latency_update got=%h/%b exp=3c00/1", o_sum, o_ready);
    end
    i_prod_vld = 1'b1; i_prod = 16'h4000;
    @(negedge clk);
    i_prod_vld = 1'b0;
    i_start = 1'b1; i_len = LEN_W'(0);
    @(negedge clk);
    i_start = 1'b0;
    checks++; if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
      errors++; $display("FAIL mid_run_busy got=%b/%b exp=1/0", o_busy, o_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({o_sum, o_flags, o_ready, o_busy, o_sum_vld} !== 23'd0) begin
      errors++; $display("FAIL mid_reset_outputs got=%h/%b/%b/%b/%b exp=0", o_sum, o_flags, o_ready, o_busy, o_sum_vld);
    end
    vld_seen = 0;
    i_prod_vld = 1'b1; i_prod = 16'h3C00; i_exception = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      i_prod_vld = 1'b0; i_exception = 1'b0;
      if (o_sum_vld) vld_seen++;
    end
    checks++; if (vld_seen !== 0) begin errors++; $display("FAIL mid_reset_no_vld got=%0d exp=0", vld_seen); end
    checks++; if (o_flags !== 4'h0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL idle_vld_ignored got=%b/%b exp=0000/0", o_flags, o_busy);
    end
    i_start = 1'b1; i_len = LEN_W'(0);
    @(negedge clk);
    i_start = 1'b0;
    checks++; if (o_sum_vld !== 1'b1 || o_sum !== 16'h0000) begin
      errors++; $display("FAIL zero_len_done got=%b/%h exp=1/0000", o_sum_vld, o_sum);
    end
    @(negedge clk);
    checks++; if (o_sum_vld !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL zero_len_idle got=%b/%b exp=0/0", o_sum_vld, o_busy);
    end
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_len = '0; i_prod = 16'h0000; i_prod_vld = 1'b0;
    i_exception = 1'b0; i_overflow = 1'b0; i_underflow = 1'b0;
    test_reset();
    test_basic();
    test_cancel();
    test_overflow();
    test_underflow();
    test_exception();
    test_truncate();
    test_in_flags();
    test_drop();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
